// File: rtl/costas_acq_ctrl.sv
// Acquisition/lock sequencer for the BPSK Costas loop: frequency sweep, settle, lock metric, tracking.
// Define COSTAS_ACQ_SWEEP_EN to enable the frequency sweep; otherwise the offset stays at START_FWC.
module costas_acq_ctrl #(
  parameter int                FWC_W        = 32,
  parameter logic [FWC_W-1:0]  START_FWC    = FWC_W'(32'h0100_0000),
  parameter logic [FWC_W-1:0]  STEP_FWC     = FWC_W'(32'h0001_0000),
  parameter int                NUM_STEPS    = 16,
  parameter int                DWELL_CYCLES = 1024,
  parameter int                MEAS_LOG2    = 6,
  parameter int                LOCK_THRESH  = 200000,
  parameter int                LOSS_COUNT   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic signed [15:0] I_in,
  input  logic signed [15:0] Q_in,
  output logic [FWC_W-1:0]   fwc_offset,
  output logic               loop_clear,
  output logic               loop_en,
  output logic               locked,
  output logic               busy,
  output logic               fail,
  output logic [7:0]         sweep_idx
);

`ifdef COSTAS_ACQ_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  localparam int ACC_W  = 17 + MEAS_LOG2;
  localparam int DW_W   = $clog2(DWELL_CYCLES + 1);
  localparam int SC_W   = (MEAS_LOG2 > 0) ? MEAS_LOG2 : 1;
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [SC_W-1:0]   SAMP_LAST  = SC_W'((1 << MEAS_LOG2) - 1);
  localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(LOSS_COUNT - 1);
  localparam logic [7:0]        LAST_IDX   = 8'(NUM_STEPS - 1);
  localparam logic signed [63:0] THRESH_X  = 64'(LOCK_THRESH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_TRACK   = 3'd4;
  localparam logic [2:0] S_FAIL    = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [FWC_W-1:0]        fwc_q, fwc_d;
  logic [7:0]              idx_q, idx_d;
  logic [DW_W-1:0]         dwell_q, dwell_d;
  logic [SC_W-1:0]         samp_q, samp_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [MISS_W-1:0]       miss_q, miss_d;
  logic                    locked_q, locked_d;
  logic                    fail_q, fail_d;
  logic                    loop_clear_q, loop_clear_d;
  logic                    loop_en_q, loop_en_d;
  logic                    busy_q, busy_d;

  logic [15:0]             abs_i, abs_q;
  logic signed [16:0]      metric;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [63:0]      sum_ext;
  logic                    win_last, win_pass;

  // Saturating magnitudes keep -32768 from flipping the metric's sign.
  always_comb begin
    abs_i    = I_in[15] ? ((I_in == 16'sh8000) ? 16'h7fff : 16'(-I_in)) : I_in;
    abs_q    = Q_in[15] ? ((Q_in == 16'sh8000) ? 16'h7fff : 16'(-Q_in)) : Q_in;
    metric   = $signed({1'b0, abs_i}) - $signed({1'b0, abs_q});
    acc_sum  = acc_q + ACC_W'(metric);
    sum_ext  = 64'(acc_sum);
    win_last = in_valid && (samp_q == SAMP_LAST);
    win_pass = sum_ext > THRESH_X;
  end

  always_comb begin
    state_d      = state_q;
    fwc_d        = fwc_q;
    idx_d        = idx_q;
    dwell_d      = dwell_q;
    samp_d       = samp_q;
    acc_d        = acc_q;
    miss_d       = miss_q;
    locked_d     = locked_q;
    fail_d       = fail_q;
    loop_clear_d = 1'b0;
    case (state_q)
      S_IDLE, S_FAIL: begin
        if (start) begin
          state_d      = S_CLEAR;
          idx_d        = 8'd0;
          fwc_d        = START_FWC;
          fail_d       = 1'b0;
          loop_clear_d = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_SETTLE;
        dwell_d = '0;
      end
      S_SETTLE: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = S_MEASURE;
          acc_d   = '0;
          samp_d  = '0;
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      S_MEASURE: begin
        if (win_last) begin
          acc_d  = '0;
          samp_d = '0;
          if (win_pass) begin
            state_d  = S_TRACK;
            locked_d = 1'b1;
            miss_d   = '0;
          end else if (SWEEP_EN && (idx_q != LAST_IDX)) begin
            state_d      = S_CLEAR;
            idx_d        = idx_q + 8'd1;
            fwc_d        = fwc_q + STEP_FWC;
            loop_clear_d = 1'b1;
          end else begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end
        end else if (in_valid) begin
          acc_d  = acc_sum;
          samp_d = samp_q + SC_W'(1);
        end
      end
      S_TRACK: begin
        if (win_last) begin
          acc_d  = '0;
          samp_d = '0;
          if (win_pass) begin
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            miss_d       = '0;
            locked_d     = 1'b0;
            state_d      = S_CLEAR;
            loop_clear_d = 1'b1;
            if (SWEEP_EN) begin
              idx_d = 8'd0;
              fwc_d = START_FWC;
            end
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end else if (in_valid) begin
          acc_d  = acc_sum;
          samp_d = samp_q + SC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    loop_en_d = (state_d == S_SETTLE) || (state_d == S_MEASURE) || (state_d == S_TRACK);
    busy_d    = (state_d != S_IDLE) && (state_d != S_FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fwc_q        <= START_FWC;
      idx_q        <= 8'd0;
      dwell_q      <= '0;
      samp_q       <= '0;
      acc_q        <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
      loop_clear_q <= 1'b0;
      loop_en_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fwc_q        <= fwc_d;
      idx_q        <= idx_d;
      dwell_q      <= dwell_d;
      samp_q       <= samp_d;
      acc_q        <= acc_d;
      miss_q       <= miss_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
      loop_clear_q <= loop_clear_d;
      loop_en_q    <= loop_en_d;
      busy_q       <= busy_d;
    end
  end

  assign fwc_offset = fwc_q;
  assign loop_clear = loop_clear_q;
  assign loop_en    = loop_en_q;
  assign locked     = locked_q;
  assign busy       = busy_q;
  assign fail       = fail_q;
  assign sweep_idx  = idx_q;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Randomized bench for costas_acq_ctrl against a timeline-based reference model.
// Expected sweep behaviour follows COSTAS_ACQ_SWEEP_EN the same way the design does.
module tb_costas_acq_ctrl;
  localparam int          DWELL   = 8;
  localparam int          WIN     = 4;
  localparam int          NSTEPS  = 4;
  localparam int          LOSS    = 2;
  localparam int          THRESH  = 1000;
  localparam logic [31:0] START_V = 32'h1000;
  localparam logic [31:0] STEP_V  = 32'h100;
`ifdef COSTAS_ACQ_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  localparam int MODE_IDLE = 0, MODE_ACQ = 1, MODE_TRACK = 2, MODE_FAILED = 3;
  localparam int K_FIXED = 0, K_GOOD = 1, K_BAD = 2, K_MIX = 3;

  logic               clk = 1'b0;
  logic               rst, start, in_valid;
  logic signed [15:0] I_in, Q_in;
  logic [31:0]        fwc_offset;
  logic               loop_clear, loop_en, locked, busy, fail;
  logic [7:0]         sweep_idx;

  int total = 0, bad = 0;
  int drv_i, drv_q;
  bit drv_start;
  int since_start = 0, first_lock = -1, clear_count = 0;

  int          m_mode, m_cyc, m_clear_at, m_idx, m_miss;
  logic [31:0] m_fwc;
  bit          m_locked;
  int          m_win[$];

  costas_acq_ctrl #(
    .FWC_W(32), .START_FWC(START_V), .STEP_FWC(STEP_V), .NUM_STEPS(NSTEPS),
    .DWELL_CYCLES(DWELL), .MEAS_LOG2(2), .LOCK_THRESH(THRESH), .LOSS_COUNT(LOSS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .I_in(I_in), .Q_in(Q_in),
    .fwc_offset(fwc_offset), .loop_clear(loop_clear), .loop_en(loop_en), .locked(locked),
    .busy(busy), .fail(fail), .sweep_idx(sweep_idx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int abs_sat(input int v);
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int window_sum();
    int s = 0;
    foreach (m_win[k]) s += m_win[k];
    return s;
  endfunction

  task automatic model_reset();
    m_mode = MODE_IDLE; m_idx = 0; m_miss = 0; m_fwc = START_V; m_locked = 0;
    m_clear_at = -100;
    m_win.delete();
  endtask

  // Cycle c's inputs are sampled at this edge; phase within a step is c minus the CLEAR cycle.
  task automatic model_edge();
    int c, r, s;
    c = m_cyc;
    case (m_mode)
      MODE_IDLE, MODE_FAILED: begin
        if (drv_start) begin
          m_mode = MODE_ACQ; m_idx = 0; m_fwc = START_V; m_clear_at = c + 1;
          m_win.delete();
        end
      end
      MODE_ACQ: begin
        r = c - m_clear_at;
        if (r > DWELL && r <= DWELL + WIN) begin
          m_win.push_back(abs_sat(drv_i) - abs_sat(drv_q));
          if (r == DWELL + WIN) begin
            s = window_sum();
            m_win.delete();
            if (s > THRESH) begin
              m_mode = MODE_TRACK; m_locked = 1; m_miss = 0;
            end else if (SWEEP && m_idx < NSTEPS - 1) begin
              m_idx++; m_fwc = m_fwc + STEP_V; m_clear_at = c + 1;
            end else begin
              m_mode = MODE_FAILED;
            end
          end
        end
      end
      MODE_TRACK: begin
        m_win.push_back(abs_sat(drv_i) - abs_sat(drv_q));
        if (m_win.size() == WIN) begin
          s = window_sum();
          m_win.delete();
          if (s > THRESH) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss == LOSS) begin
              m_miss = 0; m_locked = 0; m_mode = MODE_ACQ; m_clear_at = c + 1;
              if (SWEEP) begin m_idx = 0; m_fwc = START_V; end
            end
          end
        end
      end
      default: ;
    endcase
    m_cyc++;
  endtask

  task automatic check_all();
    bit exp_clear, exp_busy;
    exp_clear = (m_mode == MODE_ACQ) && (m_clear_at == m_cyc);
    exp_busy  = (m_mode == MODE_ACQ) || (m_mode == MODE_TRACK);
    checkOutput("loop_clear", 32'(loop_clear), 32'(exp_clear));
    checkOutput("busy", 32'(busy), 32'(exp_busy));
    checkOutput("loop_en", 32'(loop_en), 32'(exp_busy && !exp_clear));
    checkOutput("fail", 32'(fail), 32'(m_mode == MODE_FAILED));
    checkOutput("locked", 32'(locked), 32'(m_locked));
    checkOutput("sweep_idx", 32'(sweep_idx), 32'(m_idx));
    checkOutput("fwc_offset", fwc_offset, m_fwc);
  endtask

  task automatic pick_sample(input int kind);
    logic signed [15:0] t;
    case (kind)
      K_GOOD: begin
        drv_i = int'($urandom_range(1000, 32767));
        if ($urandom_range(0, 1) == 1) drv_i = ($urandom_range(0, 7) == 0) ? -32768 : -drv_i;
        drv_q = int'($urandom_range(0, 500));
        if ($urandom_range(0, 1) == 1) drv_q = -drv_q;
      end
      K_BAD: begin
        drv_q = int'($urandom_range(1000, 32767));
        if ($urandom_range(0, 1) == 1) drv_q = ($urandom_range(0, 7) == 0) ? -32768 : -drv_q;
        drv_i = int'($urandom_range(0, 200));
        if ($urandom_range(0, 1) == 1) drv_i = -drv_i;
      end
      K_MIX: begin
        t = 16'($urandom); drv_i = int'(t);
        t = 16'($urandom); drv_q = int'(t);
      end
      default: ;
    endcase
  endtask

  // Entered and left at a falling edge; each iteration drives one cycle and checks the next.
  task automatic applyStimulus(input int kind, input int n, input bit first_start, input bit rand_start);
    for (int k = 0; k < n; k++) begin
      pick_sample(kind);
      drv_start = (k == 0 && first_start) || (rand_start && $urandom_range(0, 15) == 0);
      if (k == 0 && first_start) since_start = 0;
      start = drv_start;
      I_in  = 16'(drv_i);
      Q_in  = 16'(drv_q);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      start = 1'b0;
      since_start++;
      check_all();
      if (locked === 1'b1 && first_lock < 0) first_lock = since_start;
      if (loop_clear === 1'b1) clear_count++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; I_in = '0; Q_in = '0;
    drv_i = 0; drv_q = 0; drv_start = 0; m_cyc = 0;
    model_reset();
    @(negedge clk);
    check_all();
    checkOutput("rst_fwc", fwc_offset, 32'h1000);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] lock on step 0");
    first_lock = -1; drv_i = 1000; drv_q = 0;
    applyStimulus(K_FIXED, 14, 1'b1, 1'b0);
    checkOutput("lock_cycle", 32'(first_lock), 32'd14);
    checkOutput("lock_idx", 32'(sweep_idx), 32'd0);

    $display("[TB] tracking, single miss, loss of lock");
    applyStimulus(K_GOOD, 4, 1'b0, 1'b0);
    applyStimulus(K_BAD, 4, 1'b0, 1'b0);
    applyStimulus(K_GOOD, 4, 1'b0, 1'b0);
    checkOutput("one_miss_locked", 32'(locked), 32'd1);
    applyStimulus(K_BAD, 8, 1'b0, 1'b0);
    checkOutput("loss_locked", 32'(locked), 32'd0);
    checkOutput("loss_clear", 32'(loop_clear), 32'd1);
    checkOutput("loss_fwc", fwc_offset, 32'h1000);
    applyStimulus(K_GOOD, 13, 1'b0, 1'b0);
    checkOutput("relock", 32'(locked), 32'd1);

    $display("[TB] sweep exhaustion");
    do_reset();
    drv_i = 0; drv_q = 1000; clear_count = 0;
    applyStimulus(K_FIXED, 60, 1'b1, 1'b0);
    checkOutput("sweep_fail", 32'(fail), 32'd1);
    checkOutput("sweep_busy", 32'(busy), 32'd0);
    checkOutput("sweep_fwc_hold", fwc_offset, SWEEP ? 32'h1300 : 32'h1000);
    checkOutput("sweep_clears", 32'(clear_count), SWEEP ? 32'd4 : 32'd1);

    $display("[TB] saturation");
    do_reset();
    drv_i = -32768; drv_q = 0;
    applyStimulus(K_FIXED, 22, 1'b1, 1'b0);
    checkOutput("sat_locked", 32'(locked), 32'd1);

    $display("[TB] async reset during measurement");
    do_reset();
    drv_i = 1000; drv_q = 0;
    applyStimulus(K_FIXED, 11, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(K_FIXED, 4, 1'b0, 1'b0);
    first_lock = -1;
    applyStimulus(K_FIXED, 14, 1'b1, 1'b0);
    checkOutput("restart_lock_cycle", 32'(first_lock), 32'd14);

    $display("[TB] randomized traffic");
    do_reset();
    applyStimulus(K_MIX, 600, 1'b1, 1'b1);
    for (int b = 0; b < 40; b++)
      applyStimulus(($urandom_range(0, 1) == 1) ? K_GOOD : K_BAD, 4, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/costas_acq_ctrl.md
# costas_acq_ctrl

Acquisition and lock controller for the BPSK Costas carrier-recovery loop. It sequences the loop through a coarse frequency sweep: for each step it presets the NCO frequency offset, clears the loop-filter integrator, waits for the loop to settle, then measures a lock metric on the filtered I/Q arms. It declares lock when the metric passes threshold, keeps monitoring while tracking, and restarts the sweep after sustained loss of lock. It sits between the I/Q low-pass filter outputs and the loop filter / NCO frequency-control path, in the same clock domain as the mixer.

## Interface
Parameters:
- FWC_W, 32, width of frequency-control words.
- START_FWC, 32'h0100_0000, frequency offset used for sweep step 0.
- STEP_FWC, 32'h0001_0000, offset increment per sweep step.
- NUM_STEPS, 16, number of sweep steps (2..256).
- DWELL_CYCLES, 1024, settle time per step, in clock cycles (≥1).
- MEAS_LOG2, 6, log2 of the number of valid samples per measurement window.
- LOCK_THRESH, 200000, signed threshold on the window metric.
- LOSS_COUNT, 3, consecutive failing windows in TRACK that cause loss of lock.

Ports:
- clk  in  1  system clock (loop clock).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle acquisition request.
- in_valid  in  1  I_in/Q_in qualifier.
- I_in  in  16  signed filtered I arm.
- Q_in  in  16  signed filtered Q arm.
- fwc_offset  out  FWC_W  frequency offset added ahead of the loop filter output.
- loop_clear  out  1  one-cycle pulse that clears the loop-filter integrator.
- loop_en  out  1  loop-filter enable (drives the loop filter's valid).
- locked  out  1  lock indicator.
- busy  out  1  high in every state except IDLE and FAIL.
- fail  out  1  sweep exhausted without lock.
- sweep_idx  out  8  current sweep step.

## Operation
- States: IDLE, CLEAR, SETTLE, MEASURE, TRACK, FAIL.
- IDLE/FAIL + start → CLEAR with sweep_idx=0. In FAIL, start also clears fail. start is ignored in all other states.
- CLEAR (1 cycle):
  - loop_clear=1.
  - fwc_offset = START_FWC + sweep_idx*STEP_FWC, computed modulo 2^FWC_W (wraps silently).
  - Next state: SETTLE.
- SETTLE: counts DWELL_CYCLES clock cycles, independent of in_valid, then → MEASURE. The window accumulator clears on entry to MEASURE.
- Metric per valid sample: m = |I_in| − |Q_in|.
  - Absolute values saturate: −32768 → 32767.
  - m is 17-bit signed.
  - The accumulator is (17+MEAS_LOG2)-bit signed and cannot overflow.
- MEASURE: accumulates 2^MEAS_LOG2 valid samples, then decides:
  - acc > LOCK_THRESH (strict, signed) → TRACK; locked=1; miss counter=0.
  - else if sweep_idx == NUM_STEPS−1 → FAIL.
  - else → sweep_idx+1, then CLEAR.
- TRACK: runs back-to-back windows, each the same as MEASURE.
  - A passing window resets the miss counter.
  - A failing window increments it.
  - When the counter reaches LOSS_COUNT: locked=0, sweep_idx=0, → CLEAR.
- FAIL: fail=1, loop_en=0; fwc_offset holds its last value.
- loop_en=1 in CLEAR (from the cycle after), SETTLE, MEASURE and TRACK; loop_en=0 in IDLE and FAIL.
- A sample whose in_valid coincides with the decision cycle belongs to the next window only in TRACK. In MEASURE it is discarded.

## Timing
- All outputs are registered.
- Reset values: fwc_offset=START_FWC, loop_clear=0, loop_en=0, locked=0, busy=0, fail=0, sweep_idx=0, state IDLE, all counters 0.
- rst asserted in any state forces reset values immediately (asynchronous). Operation resumes only on a start after rst deasserts.
- start sampled at edge N:
  - CLEAR at N+1: loop_clear, busy, and new fwc_offset are valid in that cycle.
  - loop_en rises at N+2.
  - SETTLE occupies N+2 .. N+1+DWELL_CYCLES.
  - MEASURE begins at N+2+DWELL_CYCLES.
- Decision latency: locked/fail/sweep_idx update on the edge after the last sample of the window is sampled (1 cycle).
- Lock-loss: locked falls and loop_clear pulses on the same cycle (CLEAR).

## Configuration
- COSTAS_ACQ_SWEEP_EN defined: full frequency sweep as described above.
- COSTAS_ACQ_SWEEP_EN undefined: no sweep.
  - fwc_offset is constant START_FWC and sweep_idx is tied to 0.
  - A failing MEASURE window goes directly to FAIL.
  - Loss of lock in TRACK re-enters CLEAR at the same offset.

## Test plan
Bench parameters: START_FWC=0x1000, STEP_FWC=0x100, NUM_STEPS=4, DWELL_CYCLES=8, MEAS_LOG2=2, LOCK_THRESH=1000, LOSS_COUNT=2, in_valid always 1.
- Reset: assert rst → all outputs at their reset values; fwc_offset=0x1000.
- Lock on step 0: start at edge 0 with I=1000, Q=0.
  - loop_clear=1 at cycle 1.
  - loop_en=1 from cycle 2.
  - locked=1 at cycle 14 (acc=4000); sweep_idx=0.
- Sweep failure: I=0, Q=1000 held.
  - fwc_offset steps 0x1000 → 0x1100 → 0x1200 → 0x1300, one loop_clear pulse per step.
  - Then fail=1, busy=0, loop_en=0; fwc_offset stays at 0x1300.
- Loss of lock: lock as in the step-0 case, then I=0, Q=1000 for 2 windows.
  - locked=0 and loop_clear pulse after the second failing window.
  - sweep_idx=0, fwc_offset=0x1000.
  - A single failing window followed by a pass keeps locked=1.
- Saturation: I=−32768, Q=0 → per-sample metric 32767, window acc=131068, locked=1; no sign flip.
- Async reset mid-MEASURE: rst pulsed → outputs return to reset values within the same cycle; a later start restarts from sweep_idx=0.
